// File: rtl/nec_ir_pkg.sv
// Shared types and timing constants for the NEC IR transmitter.
// Durations are in microseconds; the duration counter is 14 bits wide (covers 9000).
package nec_ir_pkg;

    localparam int DUR_W = 14;

    typedef logic [DUR_W-1:0] dur_t;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        REP_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK
    } state_t;

    localparam dur_t DUR_LEAD_MARK  = 14'd9000;
    localparam dur_t DUR_LEAD_SPACE = 14'd4500;
    localparam dur_t DUR_REP_SPACE  = 14'd2250;
    localparam dur_t DUR_BIT_MARK   = 14'd562;
    localparam dur_t DUR_SPACE_ZERO = 14'd563;
    localparam dur_t DUR_SPACE_ONE  = 14'd1688;
    localparam dur_t DUR_STOP_MARK  = 14'd562;

    // Clocks per carrier half-period (integer division).
    function automatic int carrier_half(input int clk_hz, input int car_hz);
        return clk_hz / (2 * car_hz);
    endfunction

    // Length of a state; a bit space depends on the bit being sent.
    function automatic dur_t dur_of(input state_t s, input logic one);
        dur_t d;
        case (s)
            LEAD_MARK:  d = DUR_LEAD_MARK;
            LEAD_SPACE: d = DUR_LEAD_SPACE;
            REP_SPACE:  d = DUR_REP_SPACE;
            BIT_MARK:   d = DUR_BIT_MARK;
            BIT_SPACE:  d = one ? DUR_SPACE_ONE : DUR_SPACE_ZERO;
            STOP_MARK:  d = DUR_STOP_MARK;
            default:    d = 14'd1;
        endcase
        return d;
    endfunction

    function automatic logic is_mark(input state_t s);
        return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
    endfunction

endpackage

// File: rtl/nec_carrier_gen.sv
// IR carrier generator: gates the mark envelope with a square-wave carrier.
// Ports: clk, rst (sync, active-high), env (1 = mark) in; out (env AND carrier) out.
import nec_ir_pkg::*;

module nec_carrier_gen #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int CARRIER_FREQ = 38_000
) (
    input  logic clk,
    input  logic rst,
    input  logic env,
    output logic out
);

    localparam int HALF = carrier_half(CLK_FREQ, CARRIER_FREQ);
    localparam int CW   = $clog2(HALF + 1);

    logic [CW-1:0] cnt;
    logic          low_half;
    logic          phase;

    // Held in the high half while no mark is active, so every mark
    // opens with a full high half-period.
    always_ff @(posedge clk) begin
        if (rst || !env) begin
            cnt      <= '0;
            low_half <= 1'b0;
        end else if (cnt == CW'(HALF - 1)) begin
            cnt      <= '0;
            low_half <= ~low_half;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign phase = ~low_half;
    assign out   = env & phase;

endmodule

// File: rtl/nec_ir_tx.sv
// NEC infrared transmitter: sends leader, 32 data bits LSB-first and stop mark, or a repeat code.
// Ports: clk100Mhz, rst, tick_us, tx_valid/tx_repeat/tx_addr/tx_cmd in; tx_ready, busy, done, ir_env, ir_out out.
import nec_ir_pkg::*;

module nec_ir_tx #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int CARRIER_FREQ = 38_000
) (
    input  logic       clk100Mhz,
    input  logic       rst,
    input  logic       tick_us,
    input  logic       tx_valid,
    input  logic       tx_repeat,
    input  logic [7:0] tx_addr,
    input  logic [7:0] tx_cmd,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ir_env,
    output logic       ir_out
);

    state_t      state, state_n;
    dur_t        cnt, cnt_n;
    logic [31:0] sr, sr_n;
    logic [4:0]  idx, idx_n;
    logic        rep, rep_n;
    logic        done_n;
    dur_t        dur;
    logic        expire;

    assign dur    = dur_of(state, sr[0]);
    assign expire = tick_us && (cnt == dur - dur_t'(1));

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sr_n    = sr;
        idx_n   = idx;
        rep_n   = rep;
        done_n  = 1'b0;

        if (state != IDLE && tick_us) begin
            cnt_n = expire ? '0 : cnt + dur_t'(1);
        end

        unique case (state)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    sr_n    = {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
                    rep_n   = tx_repeat;
                    idx_n   = '0;
                    cnt_n   = '0;
                    state_n = LEAD_MARK;
                end
            end
            LEAD_MARK: begin
                if (expire) begin
                    state_n = rep ? REP_SPACE : LEAD_SPACE;
                end
            end
            LEAD_SPACE: begin
                if (expire) begin
                    state_n = BIT_MARK;
                end
            end
            BIT_MARK: begin
                if (expire) begin
                    state_n = BIT_SPACE;
                end
            end
            BIT_SPACE: begin
                if (expire) begin
                    if (idx == 5'd31) begin
                        state_n = STOP_MARK;
                    end else begin
                        state_n = BIT_MARK;
                        sr_n    = {1'b0, sr[31:1]};
                        idx_n   = idx + 5'd1;
                    end
                end
            end
            REP_SPACE: begin
                if (expire) begin
                    state_n = STOP_MARK;
                end
            end
            STOP_MARK: begin
                if (expire) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Handshake and envelope outputs are registered from the next state
    // so they change together on the transition edge.
    always_ff @(posedge clk100Mhz) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sr       <= '0;
            idx      <= '0;
            rep      <= 1'b0;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            ir_env   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            sr       <= sr_n;
            idx      <= idx_n;
            rep      <= rep_n;
            tx_ready <= (state_n == IDLE);
            busy     <= (state_n != IDLE);
            done     <= done_n;
            ir_env   <= is_mark(state_n);
        end
    end

    nec_carrier_gen #(
        .CLK_FREQ     (CLK_FREQ),
        .CARRIER_FREQ (CARRIER_FREQ)
    ) u_carrier (
        .clk (clk100Mhz),
        .rst (rst),
        .env (ir_env),
        .out (ir_out)
    );

endmodule

// File: tb/tb_nec_ir_tx.sv
// Directed self-checking bench for nec_ir_tx.
// Covers reset, carrier, mid-frame reset, full frame with busy requests, back-to-back repeat.
module tb_nec_ir_tx;

    logic       clk;
    logic       rst;
    logic       tick_us;
    logic       tx_valid;
    logic       tx_repeat;
    logic [7:0] tx_addr;
    logic [7:0] tx_cmd;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ir_env;
    logic       ir_out;

    int n_cmp;
    int n_fail;

    // 0: no ticks, 1: tick every clock, 2: real 1 us ticks (every 100 clocks)
    int tick_mode;
    int div;

    int runs[0:127];
    int exp_runs[0:127];
    int nruns;
    int total;
    int bad_space;
    bit got_done;
    logic env_at_done;

    nec_ir_tx dut (
        .clk100Mhz (clk),
        .rst       (rst),
        .tick_us   (tick_us),
        .tx_valid  (tx_valid),
        .tx_repeat (tx_repeat),
        .tx_addr   (tx_addr),
        .tx_cmd    (tx_cmd),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .done      (done),
        .ir_env    (ir_env),
        .ir_out    (ir_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) div <= (div == 99) ? 0 : div + 1;

    assign tick_us = (tick_mode == 1) || (tick_mode == 2 && div == 0);

    // Called at the negedge of the first busy cycle; records envelope
    // run lengths until done is seen (or the budget runs out).
    task automatic capture(input int budget);
        logic lvl;
        int   cur;
        lvl = 1'b1;
        cur = 0;
        nruns = 0;
        total = 0;
        bad_space = 0;
        got_done = 1'b0;
        env_at_done = 1'bx;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                if (nruns < 128) runs[nruns] = cur;
                nruns++;
                got_done = 1'b1;
                env_at_done = ir_env;
                break;
            end
            if (ir_env === lvl) begin
                cur++;
            end else begin
                if (nruns < 128) runs[nruns] = cur;
                nruns++;
                lvl = ir_env;
                cur = 1;
            end
            if (ir_env !== 1'b1 && ir_out !== 1'b0) bad_space++;
            total++;
            @(negedge clk);
        end
    endtask

    // Issued at a negedge while idle; returns at the negedge after acceptance.
    task automatic send_req(input logic [7:0] a, input logic [7:0] c,
                            input logic r);
        tx_addr = a;
        tx_cmd = c;
        tx_repeat = r;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", tx_ready);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        n_cmp++;
        if (ir_env !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_env: got %b want 0", ir_env);
        end
        n_cmp++;
        if (ir_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: got %b want 0", ir_out);
        end
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done: got %b want 0", done);
        end
    endtask

    // Real 1 us ticks: three half-periods of 1315 clocks in the leader,
    // high first.
    task automatic test_carrier;
        int herr[3];
        int envlo;
        herr = '{0, 0, 0};
        envlo = 0;
        tick_mode = 2;
        send_req(8'h12, 8'h34, 1'b1);
        tx_valid = 1'b0;
        for (int j = 0; j < 3 * 1315; j++) begin
            if (ir_out !== (((j / 1315) % 2) == 0)) herr[j / 1315]++;
            if (ir_env !== 1'b1) envlo++;
            @(negedge clk);
        end
        for (int h = 0; h < 3; h++) begin
            n_cmp++;
            if (herr[h] !== 0) begin
                n_fail++;
                $display("FAIL carrier_half%0d: %0d bad cycles, want 0",
                         h, herr[h]);
            end
        end
        n_cmp++;
        if (envlo !== 0) begin
            n_fail++;
            $display("FAIL carrier_env: %0d low cycles, want 0", envlo);
        end
    endtask

    // Aborts the leader left running by test_carrier.
    task automatic test_reset_mid_frame;
        int dn;
        dn = 0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (ir_env !== 1'b0 || ir_out !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_ir: got env=%b out=%b want 0/0",
                     ir_env, ir_out);
        end
        n_cmp++;
        if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle: got ready=%b busy=%b want 1/0",
                     tx_ready, busy);
        end
        rst = 1'b0;
        tick_mode = 1;
        for (int i = 0; i < 10; i++) begin
            if (done !== 1'b0) dn++;
            @(negedge clk);
        end
        n_cmp++;
        if (dn !== 0) begin
            n_fail++;
            $display("FAIL midrst_done: %0d done cycles, want 0", dn);
        end
    endtask

    // addr=0x04 cmd=0x08 -> data 0xF708FB04 sent LSB-first; a different
    // request is held throughout and must be ignored.
    task automatic test_busy_ignore_frame;
        logic [31:0] data;
        data = 32'hF708FB04;
        exp_runs[0] = 9000;
        exp_runs[1] = 4500;
        for (int b = 0; b < 32; b++) begin
            exp_runs[2 + 2 * b] = 562;
            exp_runs[3 + 2 * b] = data[b] ? 1688 : 563;
        end
        exp_runs[66] = 562;
        send_req(8'h04, 8'h08, 1'b0);
        n_cmp++;
        if (tx_ready !== 1'b0 || busy !== 1'b1 || ir_env !== 1'b1) begin
            n_fail++;
            $display("FAIL accept: got ready=%b busy=%b env=%b want 0/1/1",
                     tx_ready, busy, ir_env);
        end
        tx_addr = 8'h5A;
        tx_cmd = 8'hC3;
        tx_repeat = 1'b1;
        capture(80000);
        n_cmp++;
        if (got_done !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_done: got %b want 1", got_done);
        end
        n_cmp++;
        if (total !== 68062) begin
            n_fail++;
            $display("FAIL frame_len: got %0d want 68062", total);
        end
        n_cmp++;
        if (nruns !== 67) begin
            n_fail++;
            $display("FAIL frame_runs: got %0d want 67", nruns);
        end
        for (int k = 0; k < 67; k++) begin
            n_cmp++;
            if (runs[k] !== exp_runs[k]) begin
                n_fail++;
                $display("FAIL frame_run%0d: got %0d want %0d",
                         k, runs[k], exp_runs[k]);
            end
        end
        n_cmp++;
        if (bad_space !== 0) begin
            n_fail++;
            $display("FAIL frame_space_out: %0d cycles, want 0", bad_space);
        end
        n_cmp++;
        if (env_at_done !== 1'b0 || tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_end: got env=%b ready=%b want 0/1",
                     env_at_done, tx_ready);
        end
    endtask

    // The held request (now tx_repeat=1) is taken the cycle tx_ready returns.
    task automatic test_back_to_back;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || ir_env !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy=%b env=%b done=%b want 1/1/0",
                     busy, ir_env, done);
        end
        tx_valid = 1'b0;
        capture(20000);
        n_cmp++;
        if (got_done !== 1'b1 || total !== 11812) begin
            n_fail++;
            $display("FAIL rep_len: got done=%b len=%0d want 1/11812",
                     got_done, total);
        end
        n_cmp++;
        if (nruns !== 3) begin
            n_fail++;
            $display("FAIL rep_runs: got %0d want 3", nruns);
        end
        n_cmp++;
        if (runs[0] !== 9000) begin
            n_fail++;
            $display("FAIL rep_mark: got %0d want 9000", runs[0]);
        end
        n_cmp++;
        if (runs[1] !== 2250) begin
            n_fail++;
            $display("FAIL rep_space: got %0d want 2250", runs[1]);
        end
        n_cmp++;
        if (runs[2] !== 562) begin
            n_fail++;
            $display("FAIL rep_stop: got %0d want 562", runs[2]);
        end
        n_cmp++;
        if (bad_space !== 0) begin
            n_fail++;
            $display("FAIL rep_space_out: %0d cycles, want 0", bad_space);
        end
        @(negedge clk);
        n_cmp++;
        if (tx_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rep_idle: got ready=%b busy=%b done=%b want 1/0/0",
                     tx_ready, busy, done);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        tick_mode = 0;
        div = 0;
        rst = 1'b1;
        tx_valid = 1'b0;
        tx_repeat = 1'b0;
        tx_addr = 8'h00;
        tx_cmd = 8'h00;
        test_reset;
        test_carrier;
        test_reset_mid_frame;
        test_busy_ignore_frame;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
